// File: rtl/dds_cmd_parser_pkg.sv
// Shared definitions for the DDS command parser: frame constants, command codes,
// FSM state encodings and payload lengths per command.
package dds_cmd_parser_pkg;

  localparam logic [7:0]  HEADER        = 8'hA5;
  localparam logic [31:0] F_WORD_RST    = 32'd42950;

  localparam logic [7:0]  CMD_SET_FREQ  = 8'h01;
  localparam logic [7:0]  CMD_SET_PHASE = 8'h02;
  localparam logic [7:0]  CMD_SET_WAVE  = 8'h03;
  localparam logic [7:0]  CMD_SET_EN    = 8'h04;

  localparam logic [1:0]  ST_IDLE       = 2'd0;
  localparam logic [1:0]  ST_CMD        = 2'd1;
  localparam logic [1:0]  ST_PAYLOAD    = 2'd2;
  localparam logic [1:0]  ST_CHECK      = 2'd3;

  // Zero marks an unknown command code.
  function automatic logic [2:0] payload_len(input logic [7:0] cmd);
    case (cmd)
      CMD_SET_FREQ:  payload_len = 3'd4;
      CMD_SET_PHASE: payload_len = 3'd2;
      CMD_SET_WAVE:  payload_len = 3'd1;
      CMD_SET_EN:    payload_len = 3'd1;
      default:       payload_len = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/dds_cmd_parser_byte_gap_timer.sv
// Inter-byte gap timer: counts while run is high, clears on clr, and flags expiry
// in the cycle the count reaches TIMEOUT_CYC-1 unless clr is also asserted.
module byte_gap_timer #(
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic clk_dds,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic expire
);

  localparam int unsigned CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (run && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_dds or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = run && !clr && (cnt_q == LAST);

endmodule

// File: rtl/dds_cmd_parser.sv
// Framed byte-command decoder for the DDS core: HEADER, CMD, big-endian payload, XOR
// checksum. Good frames update one DDS control field; bad or stalled frames are dropped.
module dds_cmd_parser
  import dds_cmd_parser_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic        clk_dds,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        dds_en,
  output logic        set_flag,
  output logic [31:0] f_word,
  output logic [11:0] p_word,
  output logic [1:0]  wave_type,
  output logic        frame_err,
  output logic        busy
);

  logic [1:0]  state_q, state_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] stg_q, stg_d;
  logic [7:0]  chk_q, chk_d;
  logic [31:0] f_q, f_d;
  logic [11:0] p_q, p_d;
  logic [1:0]  w_q, w_d;
  logic        en_q, en_d;
  logic        set_q, set_d;
  logic        err_q, err_d;
  logic        expire;
  logic        busy_w;

  assign busy_w = (state_q != ST_IDLE);

  byte_gap_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_gap (
    .clk_dds (clk_dds),
    .rst     (rst),
    .clr     (rx_valid || !busy_w),
    .run     (busy_w),
    .expire  (expire)
  );

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    cnt_d   = cnt_q;
    stg_d   = stg_q;
    chk_d   = chk_q;
    f_d     = f_q;
    p_d     = p_q;
    w_d     = w_q;
    en_d    = en_q;
    set_d   = 1'b0;
    err_d   = 1'b0;
    if (expire) begin
      state_d = ST_IDLE;
      err_d   = 1'b1;
    end else if (rx_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (rx_data == HEADER) begin
            state_d = ST_CMD;
          end
        end
        ST_CMD: begin
          if (payload_len(rx_data) != 3'd0) begin
            cmd_d   = rx_data;
            cnt_d   = payload_len(rx_data);
            chk_d   = rx_data;
            state_d = ST_PAYLOAD;
          end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_PAYLOAD: begin
          // Newest byte lands in the low bits, so short payloads sit right-aligned.
          stg_d = {stg_q[23:0], rx_data};
          chk_d = chk_q ^ rx_data;
          if (cnt_q == 3'd1) begin
            state_d = ST_CHECK;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
        default: begin
          if (rx_data == chk_q) begin
            set_d = 1'b1;
            case (cmd_q)
              CMD_SET_FREQ:  f_d  = stg_q;
              CMD_SET_PHASE: p_d  = stg_q[11:0];
              CMD_SET_WAVE:  w_d  = stg_q[1:0];
              default:       en_d = stg_q[0];
            endcase
          end else begin
            err_d = 1'b1;
          end
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_dds or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cmd_q   <= '0;
      cnt_q   <= '0;
      stg_q   <= '0;
      chk_q   <= '0;
      f_q     <= F_WORD_RST;
      p_q     <= '0;
      w_q     <= '0;
      en_q    <= 1'b0;
      set_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      cnt_q   <= cnt_d;
      stg_q   <= stg_d;
      chk_q   <= chk_d;
      f_q     <= f_d;
      p_q     <= p_d;
      w_q     <= w_d;
      en_q    <= en_d;
      set_q   <= set_d;
      err_q   <= err_d;
    end
  end

  assign dds_en    = en_q;
  assign set_flag  = set_q;
  assign f_word    = f_q;
  assign p_word    = p_q;
  assign wave_type = w_q;
  assign frame_err = err_q;
  assign busy      = busy_w;

endmodule

// File: tb/tb_dds_cmd_parser.sv
// Testbench for dds_cmd_parser: table of spec frames, hand-written timeout/reset
// sequences, and random frames checked against a frame-level reference model.
`timescale 1ns/1ps
module tb_dds_cmd_parser;

  localparam int unsigned TO = 40;

  logic        clk_dds = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        dds_en, set_flag, frame_err, busy;
  logic [31:0] f_word;
  logic [11:0] p_word;
  logic [1:0]  wave_type;

  always #5 clk_dds = ~clk_dds;

  dds_cmd_parser #(
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk_dds   (clk_dds),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .dds_en    (dds_en),
    .set_flag  (set_flag),
    .f_word    (f_word),
    .p_word    (p_word),
    .wave_type (wave_type),
    .frame_err (frame_err),
    .busy      (busy)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned n_set  = 0;
  int unsigned n_err  = 0;

  always @(negedge clk_dds) begin
    if (!rst) begin
      if (set_flag)  n_set++;
      if (frame_err) n_err++;
    end
  end

  // Reference model state: the DDS controls as seen from outside.
  logic [31:0] m_f;
  logic [11:0] m_p;
  logic [1:0]  m_w;
  logic        m_en;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, expv);
    end
  endtask

  // Caller is positioned at a negedge; the byte is captured at the following posedge.
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk_dds);
    rx_valid = 1'b0;
  endtask

  task automatic model_reset();
    m_f = 32'd42950; m_p = '0; m_w = '0; m_en = 1'b0;
  endtask

  // Frame-level reference: decide outcome from the byte list and apply it.
  task automatic model_frame(input logic [7:0] fr[$], output int es, output int ee);
    int unsigned n;
    logic [7:0]  x;
    logic [31:0] val;
    es = 0; ee = 0;
    case (fr[1])
      8'h01: n = 4;
      8'h02: n = 2;
      8'h03: n = 1;
      8'h04: n = 1;
      default: n = 0;
    endcase
    if (n == 0) begin
      ee = 1;
      return;
    end
    x = 8'h00;
    val = 0;
    for (int unsigned i = 1; i <= n + 1; i++) x ^= fr[i];
    for (int unsigned i = 0; i < n; i++) val = val * 256 + 32'(fr[2 + i]);
    if (fr[n + 2] != x) begin
      ee = 1;
      return;
    end
    es = 1;
    case (fr[1])
      8'h01: m_f  = val;
      8'h02: m_p  = val[11:0];
      8'h03: m_w  = val[1:0];
      default: m_en = val[0];
    endcase
  endtask

  task automatic check_model(input string tag, input int es, input int ee,
                             input int unsigned s0, input int unsigned e0);
    check({tag, "_f_word"},    f_word,          m_f);
    check({tag, "_p_word"},    32'(p_word),     32'(m_p));
    check({tag, "_wave"},      32'(wave_type),  32'(m_w));
    check({tag, "_dds_en"},    32'(dds_en),     32'(m_en));
    check({tag, "_set_cnt"},   n_set - s0,      32'(es));
    check({tag, "_err_cnt"},   n_err - e0,      32'(ee));
    check({tag, "_busy"},      32'(busy),       32'd0);
  endtask

  task automatic run_frame(input logic [7:0] fr[$], input int unsigned maxgap, input string tag);
    int es, ee;
    int unsigned s0, e0;
    s0 = n_set; e0 = n_err;
    model_frame(fr, es, ee);
    for (int unsigned i = 0; i < fr.size(); i++) begin
      if (i == 1 && ee == 1 && fr[1] inside {8'h01, 8'h02, 8'h03, 8'h04}) begin end
      send_byte(fr[i]);
      if (i + 1 < fr.size() && maxgap > 0) repeat ($urandom_range(0, maxgap)) @(negedge clk_dds);
    end
    repeat (2) @(negedge clk_dds);
    check_model(tag, es, ee, s0, e0);
  endtask

  typedef struct {
    logic [7:0]  b [8];
    int          n;
    int          es;
    int          ee;
    logic [31:0] f;
    logic [11:0] p;
    logic [1:0]  w;
    logic        en;
  } vec_t;

  vec_t tbl [8];

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] fr[$];
    int unsigned s0, e0, cyc;

    tbl[0] = '{'{8'hA5, 8'h01, 8'h00, 8'h00, 8'hA7, 8'hC6, 8'h60, 8'h00}, 7, 1, 0, 32'h0000A7C6, 12'h000, 2'd0, 1'b0};
    tbl[1] = '{'{8'hA5, 8'h02, 8'h08, 8'h00, 8'h0A, 8'h00, 8'h00, 8'h00}, 5, 1, 0, 32'h0000A7C6, 12'h800, 2'd0, 1'b0};
    tbl[2] = '{'{8'hA5, 8'h03, 8'h02, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00}, 4, 1, 0, 32'h0000A7C6, 12'h800, 2'd2, 1'b0};
    tbl[3] = '{'{8'hA5, 8'h04, 8'h01, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00}, 4, 1, 0, 32'h0000A7C6, 12'h800, 2'd2, 1'b1};
    tbl[4] = '{'{8'hA5, 8'h01, 8'h00, 8'h00, 8'hA7, 8'hC6, 8'h61, 8'h00}, 7, 0, 1, 32'h0000A7C6, 12'h800, 2'd2, 1'b1};
    tbl[5] = '{'{8'hA5, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 2, 0, 1, 32'h0000A7C6, 12'h800, 2'd2, 1'b1};
    tbl[6] = '{'{8'h00, 8'hFF, 8'h13, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3, 0, 0, 32'h0000A7C6, 12'h800, 2'd2, 1'b1};
    tbl[7] = '{'{8'hA5, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h09, 8'h00}, 7, 1, 0, 32'h12345678, 12'h800, 2'd2, 1'b1};

    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk_dds);
    rst = 1'b0;
    @(negedge clk_dds);
    check("rst_f_word",   f_word,          32'd42950);
    check("rst_p_word",   32'(p_word),     32'd0);
    check("rst_wave",     32'(wave_type),  32'd0);
    check("rst_dds_en",   32'(dds_en),     32'd0);
    check("rst_set_flag", 32'(set_flag),   32'd0);
    check("rst_busy",     32'(busy),       32'd0);

    // Spec frames, back to back, with pulse-shape checks on the CHK cycle.
    for (int unsigned v = 0; v < 8; v++) begin
      s0 = n_set; e0 = n_err;
      for (int k = 0; k < tbl[v].n; k++) send_byte(tbl[v].b[k]);
      check($sformatf("v%0d_set_now", v), 32'(set_flag),  32'(tbl[v].es));
      check($sformatf("v%0d_err_now", v), 32'(frame_err), 32'(tbl[v].ee));
      check($sformatf("v%0d_f_word", v),  f_word,         tbl[v].f);
      @(negedge clk_dds);
      check($sformatf("v%0d_set_drop", v), 32'(set_flag), 32'd0);
      check($sformatf("v%0d_p_word", v),  32'(p_word),    32'(tbl[v].p));
      check($sformatf("v%0d_wave", v),    32'(wave_type), 32'(tbl[v].w));
      check($sformatf("v%0d_dds_en", v),  32'(dds_en),    32'(tbl[v].en));
      check($sformatf("v%0d_set_cnt", v), n_set - s0,     32'(tbl[v].es));
      check($sformatf("v%0d_err_cnt", v), n_err - e0,     32'(tbl[v].ee));
      check($sformatf("v%0d_busy", v),    32'(busy),      32'd0);
    end
    m_f = tbl[7].f; m_p = tbl[7].p; m_w = tbl[7].w; m_en = tbl[7].en;

    // Stalled frame: frame_err exactly TO cycles after the last byte.
    e0 = n_err;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h12);
    check("to_busy_mid", 32'(busy), 32'd1);
    cyc = 0;
    while (!frame_err && cyc < 3 * TO) begin
      @(negedge clk_dds);
      cyc++;
    end
    check("to_latency", cyc, TO);
    check("to_busy_after", 32'(busy), 32'd0);
    @(negedge clk_dds);
    check("to_err_cnt", n_err - e0, 32'd1);
    fr = '{8'hA5, 8'h03, 8'h01, 8'h02};
    run_frame(fr, 0, "after_to");

    // Byte arriving in the expiry cycle keeps the frame alive.
    s0 = n_set; e0 = n_err;
    send_byte(8'hA5);
    repeat (TO - 1) @(negedge clk_dds);
    send_byte(8'h03); send_byte(8'h02); send_byte(8'h01);
    repeat (2) @(negedge clk_dds);
    m_w = 2'd2;
    check_model("expiry_byte", 1, 0, s0, e0);

    // Asynchronous reset in the middle of a payload.
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h12);
    check("pre_rst_en", 32'(dds_en), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_f_word", f_word,         32'd42950);
    check("arst_p_word", 32'(p_word),    32'd0);
    check("arst_wave",   32'(wave_type), 32'd0);
    check("arst_dds_en", 32'(dds_en),    32'd0);
    check("arst_busy",   32'(busy),      32'd0);
    @(negedge clk_dds);
    rst = 1'b0;
    model_reset();
    @(negedge clk_dds);
    fr = '{8'hA5, 8'h02, 8'h01, 8'h23, 8'h20};
    run_frame(fr, 0, "post_rst");

    // Random frames with garbage, bad checksums and unknown commands.
    for (int unsigned t = 0; t < 80; t++) begin
      logic [7:0] cmd, x, g;
      int unsigned n;
      repeat ($urandom_range(0, 2)) begin
        g = 8'($urandom);
        if (g == 8'hA5) g = 8'h00;
        send_byte(g);
      end
      if ($urandom_range(0, 9) == 0) cmd = 8'($urandom_range(5, 255));
      else cmd = 8'($urandom_range(1, 4));
      fr = '{8'hA5, cmd};
      n = (cmd == 8'h01) ? 4 : (cmd == 8'h02) ? 2 : (cmd inside {8'h03, 8'h04}) ? 1 : 0;
      if (n != 0) begin
        x = cmd;
        for (int unsigned i = 0; i < n; i++) begin
          g = 8'($urandom);
          fr.push_back(g);
          x ^= g;
        end
        if ($urandom_range(0, 4) == 0) x ^= 8'($urandom_range(1, 255));
        fr.push_back(x);
      end
      run_frame(fr, 3, $sformatf("rnd%0d", t));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
